// File: rtl/multi_scoreboard.sv
// N-channel binary-to-BCD score driver: one shared double-dabble engine sweeps the
// channels in turn and registers BCD and 7-segment patterns. Optional LEADING_ZERO_BLANK_EN.
//
// state  | meaning
// IDLE   | waiting for an update request
// LOAD   | seed shift register with the current channel's snapshot
// SHIFT  | one double-dabble step per cycle, INPUT_LENGTH steps
// WRITE  | commit digits, segments and overflow for the current channel
// FINISH | done pulse; restart at once if a request arrived during the sweep
module multi_scoreboard #(
    parameter int INPUT_LENGTH = 8,
    parameter int N_DIGITS     = 2,
    parameter int N_CHANNELS   = 2
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [N_CHANNELS*INPUT_LENGTH-1:0] binary,
    input  logic                               update,
    output logic                               busy,
    output logic                               done,
    output logic [N_CHANNELS*N_DIGITS*4-1:0]   bcd,
    output logic [N_CHANNELS*N_DIGITS*7-1:0]   segments,
    output logic [N_CHANNELS-1:0]              overflow
);

    localparam int BW   = N_DIGITS * 4;
    localparam int SW   = BW + INPUT_LENGTH;
    localparam int CHW  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int CNTW = $clog2(INPUT_LENGTH + 1);
    localparam int CMPW = (INPUT_LENGTH > 32) ? INPUT_LENGTH : 32;

    function automatic int unsigned pow10_minus1(input int n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r - 1;
    endfunction

    localparam int unsigned MAX_VAL  = pow10_minus1(N_DIGITS);
    localparam logic [CHW-1:0] LAST_CH = CHW'(N_CHANNELS - 1);

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, WRITE, FINISH} state_t;

    state_t                           state, next_state;
    logic [N_CHANNELS*INPUT_LENGTH-1:0] snapshot;
    logic [CHW-1:0]                   ch;
    logic [SW-1:0]                    shreg, adj;
    logic [CNTW-1:0]                  cnt;
    logic                             pending;
    logic [INPUT_LENGTH-1:0]          cur_val;
    logic                             sat;
    logic [BW-1:0]                    wr_bcd;
    logic [N_DIGITS*7-1:0]            wr_seg;

    assign cur_val = snapshot[ch*INPUT_LENGTH +: INPUT_LENGTH];
    assign sat     = CMPW'(cur_val) > CMPW'(MAX_VAL);
    assign wr_bcd  = sat ? {N_DIGITS{4'h9}} : shreg[INPUT_LENGTH +: BW];

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (update) next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (cnt == CNTW'(1)) next_state = WRITE;
            WRITE:   next_state = (ch == LAST_CH) ? FINISH : LOAD;
            FINISH:  next_state = (pending || update) ? LOAD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Add-3 correction on the BCD nibbles only; the binary tail passes through.
    always_comb begin
        adj = shreg;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (shreg[INPUT_LENGTH + d*4 +: 4] >= 4'd5)
                adj[INPUT_LENGTH + d*4 +: 4] = shreg[INPUT_LENGTH + d*4 +: 4] + 4'd3;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    always_comb begin
        wr_seg = '0;
        lead   = 1'b1;
        for (int d = N_DIGITS - 1; d >= 0; d--) begin
            wr_seg[d*7 +: 7] = seg7(wr_bcd[d*4 +: 4]);
            if (!sat && lead && d != 0 && wr_bcd[d*4 +: 4] == 4'd0)
                wr_seg[d*7 +: 7] = 7'h00;
            else
                lead = 1'b0;
        end
    end
`else
    always_comb begin
        wr_seg = '0;
        for (int d = 0; d < N_DIGITS; d++)
            wr_seg[d*7 +: 7] = seg7(wr_bcd[d*4 +: 4]);
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            snapshot <= '0;
            ch       <= '0;
            shreg    <= '0;
            cnt      <= '0;
            pending  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            segments <= '0;
            overflow <= '0;
        end else begin
            state <= next_state;
            busy  <= (next_state == LOAD) || (next_state == SHIFT) || (next_state == WRITE);
            done  <= (next_state == FINISH);
            case (state)
                IDLE: begin
                    if (update) begin
                        snapshot <= binary;
                        ch       <= '0;
                    end
                end
                LOAD: begin
                    shreg <= {{BW{1'b0}}, cur_val};
                    cnt   <= CNTW'(INPUT_LENGTH);
                    if (update) pending <= 1'b1;
                end
                SHIFT: begin
                    shreg <= adj << 1;
                    cnt   <= cnt - 1'b1;
                    if (update) pending <= 1'b1;
                end
                WRITE: begin
                    bcd[ch*BW +: BW]                      <= wr_bcd;
                    segments[ch*N_DIGITS*7 +: N_DIGITS*7] <= wr_seg;
                    overflow[ch]                          <= sat;
                    if (ch != LAST_CH) ch <= ch + 1'b1;
                    if (update) pending <= 1'b1;
                end
                FINISH: begin
                    pending <= 1'b0;
                    if (pending || update) begin
                        snapshot <= binary;
                        ch       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_scoreboard.sv
// Directed bench for multi_scoreboard: default 2x2-digit instance plus a 3-channel,
// 3-digit, 10-bit instance for the saturation/latency corner.
module tb_multi_scoreboard;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] binary;
    logic        update;
    logic        busy, done;
    logic [15:0] bcd;
    logic [27:0] segments;
    logic [1:0]  overflow;

    logic [29:0] binary2;
    logic        update2;
    logic        busy2, done2;
    logic [35:0] bcd2;
    logic [62:0] segments2;
    logic [2:0]  overflow2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    multi_scoreboard dut (
        .clock(clock), .reset_n(reset_n), .binary(binary), .update(update),
        .busy(busy), .done(done), .bcd(bcd), .segments(segments), .overflow(overflow)
    );

    multi_scoreboard #(.INPUT_LENGTH(10), .N_DIGITS(3), .N_CHANNELS(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .binary(binary2), .update(update2),
        .busy(busy2), .done(done2), .bcd(bcd2), .segments(segments2), .overflow(overflow2)
    );

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [1:0] eo;
    } vec_t;

    vec_t vecs [8];
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h00;
        if (d <= 4'd9) s = seg_tab[d];
        return s;
    endfunction

    function automatic logic [13:0] exp_seg(input logic [7:0] b);
        logic [13:0] s;
        s = {seg_of(b[7:4]), seg_of(b[3:0])};
`ifdef LEADING_ZERO_BLANK_EN
        if (b[7:4] == 4'd0) s[13:7] = 7'h00;
`endif
        return s;
    endfunction

    function automatic logic [7:0] ref_bcd(input int v);
        logic [7:0] r;
        if (v > 99) r = 8'h99;
        else r = {4'(v / 10), 4'(v % 10)};
        return r;
    endfunction

    task automatic run_sweep(input logic [7:0] b0, input logic [7:0] b1, output int lat);
        binary = {b1, b0};
        update = 1'b1;
        tick();
        update = 1'b0;
        check("busy_start", busy, 1'b1);
        lat = 1;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, dones, first_k, busy_seen;
        int v0, v1;

        vecs[0] = '{8'd42,  8'd7,   8'h42, 8'h07, 2'b00};
        vecs[1] = '{8'd150, 8'd99,  8'h99, 8'h99, 2'b01};
        vecs[2] = '{8'd0,   8'd255, 8'h00, 8'h99, 2'b10};
        vecs[3] = '{8'd100, 8'd9,   8'h99, 8'h09, 2'b01};
        vecs[4] = '{8'd99,  8'd100, 8'h99, 8'h99, 2'b10};
        vecs[5] = '{8'd10,  8'd1,   8'h10, 8'h01, 2'b00};
        vecs[6] = '{8'd58,  8'd63,  8'h58, 8'h63, 2'b00};
        vecs[7] = '{8'd200, 8'd37,  8'h99, 8'h37, 2'b01};

        reset_n = 1'b0;
        update  = 1'b0;
        update2 = 1'b0;
        binary  = '0;
        binary2 = '0;
        repeat (2) tick();
        check("rst_bcd", bcd, 16'h0);
        check("rst_seg", segments, 28'h0);
        check("rst_ovf", overflow, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_sweep(vecs[i].b0, vecs[i].b1, lat);
            check($sformatf("v%0d_latency", i), lat, 21);
            check($sformatf("v%0d_bcd", i), bcd, {vecs[i].e1, vecs[i].e0});
            check($sformatf("v%0d_seg", i), segments, {exp_seg(vecs[i].e1), exp_seg(vecs[i].e0)});
            check($sformatf("v%0d_ovf", i), overflow, vecs[i].eo);
            check($sformatf("v%0d_busy_done", i), busy, 1'b0);
            tick();
            check($sformatf("v%0d_done_pulse", i), done, 1'b0);
        end

        for (int i = 0; i < 16; i++) begin
            v0 = int'($urandom_range(0, 255));
            v1 = int'($urandom_range(0, 255));
            run_sweep(8'(v0), 8'(v1), lat);
            check($sformatf("rnd%0d_bcd", i), bcd, {ref_bcd(v1), ref_bcd(v0)});
            check($sformatf("rnd%0d_ovf", i), overflow, {v1 > 99, v0 > 99});
            tick();
        end

        // Requests during a sweep collapse into one follow-up sweep with values taken in FINISH.
        binary = {8'd22, 8'd11};
        update = 1'b1;
        tick();
        update  = 1'b0;
        dones   = 0;
        first_k = 0;
        for (int k = 2; k <= 80; k++) begin
            update = (k == 3 || k == 10);
            if (k == 12) binary = {8'd44, 8'd33};
            tick();
            update = 1'b0;
            if (first_k != 0 && k == first_k + 1) check("pend_busy_again", busy, 1'b1);
            if (done) begin
                dones++;
                if (dones == 1) begin
                    first_k = k;
                    check("pend_first_lat", k, 21);
                    check("pend_first_bcd", bcd, 16'h2211);
                end else if (dones == 2) begin
                    check("pend_second_gap", k - first_k, 21);
                    check("pend_second_bcd", bcd, 16'h4433);
                end
            end
        end
        check("pend_done_count", dones, 2);

        // Reset in the middle of a sweep with a pending request queued.
        binary = {8'd88, 8'd77};
        update = 1'b1;
        tick();
        update = 1'b0;
        for (int k = 2; k <= 12; k++) begin
            update = (k == 5);
            tick();
            update = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("mid_rst_bcd", bcd, 16'h0);
        check("mid_rst_seg", segments, 28'h0);
        check("mid_rst_ovf", overflow, 2'b00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        repeat (2) tick();
        reset_n = 1'b1;
        dones = 0;
        busy_seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) dones++;
            if (busy) busy_seen++;
        end
        check("post_rst_dones", dones, 0);
        check("post_rst_busy", busy_seen, 0);
        check("post_rst_bcd", bcd, 16'h0);

        // Wide configuration: 3 channels, 3 digits, 10-bit scores.
        binary2 = {10'd1023, 10'd999, 10'd5};
        update2 = 1'b1;
        tick();
        update2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 200) begin
            tick();
            lat++;
        end
        check("w_latency", lat, 37);
        check("w_bcd", bcd2, {12'h999, 12'h999, 12'h005});
        check("w_ovf", overflow2, 3'b100);
`ifdef LEADING_ZERO_BLANK_EN
        check("w_seg_ch0", segments2[20:0], {7'h00, 7'h00, 7'h6D});
`else
        check("w_seg_ch0", segments2[20:0], {7'h3F, 7'h3F, 7'h6D});
`endif
        check("w_seg_ch2", segments2[62:42], {7'h6F, 7'h6F, 7'h6F});
        tick();
        check("w_done_pulse", done2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
